// File: rtl/fp_addsub_core.sv
// ---------------------------------------------------------------------------
// fp_addsub_core
//   Multi-cycle IEEE-754 single-precision adder/subtractor. Operands arrive
//   already decomposed (sign/exponent/fraction plus alignment metadata and
//   special-value flags). The small mantissa is aligned one bit per cycle,
//   added or subtracted in one cycle, then normalized one bit per cycle.
//   Rounding is truncation; subnormals are flushed to zero.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   valid_i / ready_o      operand handshake (ready_o high only when idle)
//   sub_i                  1 = x - y, 0 = x + y
//   x_*_i, y_*_i           operand sign, biased exponent, fraction
//   x_greater_i            x_exp > y_exp (strict)
//   exp_shift_i            |x_exp - y_exp|
//   infinity_i, nan_i      either operand is infinity / NaN
//   valid_o / ready_i      result handshake
//   result_o               packed single-precision result
//   overflow_o             finite inputs produced infinity
//   underflow_o            nonzero result flushed to zero
// ---------------------------------------------------------------------------
module fp_addsub_core #(
  parameter int          MAX_SHIFT = 25,
  parameter logic [31:0] QNAN      = 32'h7FC00000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        sub_i,
  input  logic        x_sign_i,
  input  logic        y_sign_i,
  input  logic [7:0]  x_exp_i,
  input  logic [7:0]  y_exp_i,
  input  logic [22:0] x_frac_i,
  input  logic [22:0] y_frac_i,
  input  logic        x_greater_i,
  input  logic [7:0]  exp_shift_i,
  input  logic        infinity_i,
  input  logic        nan_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        overflow_o,
  output logic        underflow_o
);

  localparam int CW = $clog2(MAX_SHIFT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE
  } state_t;

  state_t      r_state, w_state_next;
  logic [23:0] r_mant_big, r_mant_small;
  logic        r_sign_big, r_sign_small;
  logic [7:0]  r_exp;
  logic [CW-1:0] r_cnt;
  logic [24:0] r_sum;
  logic        r_res_sign;
  logic [31:0] r_result;
  logic        r_ovf, r_unf;

  // Operand decode at the accept edge
  logic        w_y_sign, w_x_zero, w_y_zero, w_x_inf, w_y_inf, w_x_big;
  logic        w_special;
  logic [31:0] w_special_result;
  logic [23:0] w_x_mant, w_y_mant;
  logic [CW-1:0] w_cnt_load;

  assign w_y_sign = y_sign_i ^ sub_i;
  assign w_x_zero = (x_exp_i == 8'd0);
  assign w_y_zero = (y_exp_i == 8'd0);
  assign w_x_inf  = (x_exp_i == 8'hFF);
  assign w_y_inf  = (y_exp_i == 8'hFF);
  // x is the big operand on equal exponents
  assign w_x_big  = x_greater_i | (exp_shift_i == 8'd0);
  // Zero-exponent operands (including subnormals) contribute a zero mantissa
  assign w_x_mant = w_x_zero ? 24'd0 : {1'b1, x_frac_i};
  assign w_y_mant = w_y_zero ? 24'd0 : {1'b1, y_frac_i};
  assign w_cnt_load = (exp_shift_i > 8'(MAX_SHIFT)) ? CW'(MAX_SHIFT)
                                                    : exp_shift_i[CW-1:0];
  assign w_special = nan_i | infinity_i | (w_x_zero & w_y_zero);

  always_comb begin
    w_special_result = {x_sign_i & w_y_sign, 31'd0};
    if (nan_i)
      w_special_result = QNAN;
    else if (w_x_inf && w_y_inf && (x_sign_i != w_y_sign))
      w_special_result = QNAN;
    else if (w_x_inf)
      w_special_result = {x_sign_i, 8'hFF, 23'd0};
    else if (w_y_inf)
      w_special_result = {w_y_sign, 8'hFF, 23'd0};
  end

  // Add/subtract of the aligned magnitudes
  logic        w_same_sign, w_big_ge;
  logic [24:0] w_sum;
  logic        w_sum_sign;

  assign w_same_sign = (r_sign_big == r_sign_small);
  assign w_big_ge    = (r_mant_big >= r_mant_small);

  always_comb begin
    w_sum      = {1'b0, r_mant_big} + {1'b0, r_mant_small};
    w_sum_sign = r_sign_big;
    if (!w_same_sign) begin
      if (w_big_ge) begin
        w_sum = {1'b0, r_mant_big} - {1'b0, r_mant_small};
      end else begin
        w_sum      = {1'b0, r_mant_small} - {1'b0, r_mant_big};
        w_sum_sign = r_sign_small;
      end
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    ready_o      = 1'b0;
    valid_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (valid_i)
          w_state_next = w_special ? S_DONE : S_ALIGN;
      end
      // Leaving on the cycle the last shift happens keeps ALIGN at max(n,1) cycles
      S_ALIGN: if (r_cnt <= CW'(1)) w_state_next = S_ADD;
      S_ADD:   w_state_next = (w_sum == 25'd0) ? S_DONE : S_NORM;
      S_NORM: begin
        if (r_sum[24])
          w_state_next = (r_exp == 8'd254) ? S_DONE : S_NORM;
        else if (!r_sum[23])
          w_state_next = (r_exp == 8'd1) ? S_DONE : S_NORM;
        else
          w_state_next = S_DONE;
      end
      S_DONE: begin
        valid_o = 1'b1;
        if (ready_i)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  // Datapath
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mant_big   <= '0;
      r_mant_small <= '0;
      r_sign_big   <= 1'b0;
      r_sign_small <= 1'b0;
      r_exp        <= '0;
      r_cnt        <= '0;
      r_sum        <= '0;
      r_res_sign   <= 1'b0;
      r_result     <= '0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_cnt <= w_cnt_load;
            if (w_x_big) begin
              r_mant_big   <= w_x_mant;
              r_mant_small <= w_y_mant;
              r_sign_big   <= x_sign_i;
              r_sign_small <= w_y_sign;
              r_exp        <= x_exp_i;
            end else begin
              r_mant_big   <= w_y_mant;
              r_mant_small <= w_x_mant;
              r_sign_big   <= w_y_sign;
              r_sign_small <= x_sign_i;
              r_exp        <= y_exp_i;
            end
            if (w_special)
              r_result <= w_special_result;
          end
        end
        S_ALIGN: begin
          if (r_cnt != '0) begin
            r_mant_small <= r_mant_small >> 1;
            r_cnt        <= r_cnt - CW'(1);
          end
        end
        S_ADD: begin
          r_sum      <= w_sum;
          r_res_sign <= w_sum_sign;
          if (w_sum == 25'd0)
            r_result <= 32'd0;
        end
        S_NORM: begin
          if (r_sum[24]) begin
            // A right shift out of exponent 254 lands on 255: infinity
            if (r_exp == 8'd254) begin
              r_result <= {r_res_sign, 8'hFF, 23'd0};
              r_ovf    <= 1'b1;
            end else begin
              r_sum <= r_sum >> 1;
              r_exp <= r_exp + 8'd1;
            end
          end else if (!r_sum[23]) begin
            // A left shift from exponent 1 would produce a subnormal: flush
            if (r_exp == 8'd1) begin
              r_result <= {r_res_sign, 31'd0};
              r_unf    <= 1'b1;
            end else begin
              r_sum <= r_sum << 1;
              r_exp <= r_exp - 8'd1;
            end
          end else begin
            r_result <= {r_res_sign, r_exp, r_sum[22:0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o    = r_result;
  assign overflow_o  = r_ovf;
  assign underflow_o = r_unf;

endmodule
